// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo path sequencer:
// state encoding and default geometry parameters.
package mc_pkg;

    localparam int N_STAGES_DEF = 5;
    localparam int CNT_W_DEF    = 17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mc_stage_shifter.sv
// Stage-enable register for the path pipeline.
// Ports: clk, rst (sync, active-low), clear (zero all stages),
//        shift (advance by one stage), shift_in (new bit0),
//        stage_en (registered per-stage enables, bit0 = first stage).
module mc_stage_shifter
    import mc_pkg::*;
#(
    parameter int N_STAGES = N_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift,
    input  logic                shift_in,
    output logic [N_STAGES-1:0] stage_en
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_en <= '0;
        end else if (clear) begin
            stage_en <= '0;
        end else if (shift) begin
            stage_en <= {stage_en[N_STAGES-2:0], shift_in};
        end
    end

endmodule

// File: rtl/mc_path_sequencer.sv
// Sequences a run of num_paths paths through an N_STAGES-deep
// path pipeline: fill, one issue per cycle, drain, completion pulse.
// Ports: clk, rst (sync, active-low), load, num_paths, stall, abort;
//        stage_en, path_valid, path_idx, busy, done, aborted.
module mc_path_sequencer
    import mc_pkg::*;
#(
    parameter int N_STAGES = N_STAGES_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CNT_W-1:0]    num_paths,
    input  logic                stall,
    input  logic                abort,
    output logic [N_STAGES-1:0] stage_en,
    output logic                path_valid,
    output logic [CNT_W-1:0]    path_idx,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] path_cnt;
    logic [CNT_W-1:0] num_lat;
    logic             issue;
    logic             more;
    logic             shift;
    logic             shift_in;
    logic             clear;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             lat_en;

    mc_stage_shifter #(
        .N_STAGES (N_STAGES)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift    (shift),
        .shift_in (shift_in),
        .stage_en (stage_en)
    );

    assign issue = (state == FILL || state == RUN) && stage_en[0] && !stall;
    // Cleared on the issue of the last path, which forces DRAIN
    // and keeps path_cnt from ever wrapping.
    assign more  = (path_cnt != (num_lat - CNT_W'(1)));

    assign path_valid = issue;
    assign path_idx   = path_cnt;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        shift_in  = 1'b0;
        clear     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        lat_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    if (num_paths != '0) begin
                        // stage_en is zero in IDLE, so shifting in a
                        // one yields the first-stage enable.
                        lat_en    = 1'b1;
                        cnt_clr   = 1'b1;
                        shift     = 1'b1;
                        shift_in  = 1'b1;
                        state_nxt = FILL;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            FILL, RUN: begin
                if (abort) begin
                    clear     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (issue) begin
                    cnt_inc  = 1'b1;
                    shift    = 1'b1;
                    shift_in = more;
                    if (!more) begin
                        state_nxt = DRAIN;
                    end else if (&stage_en[N_STAGES-2:0]) begin
                        state_nxt = RUN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    clear     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (!stall) begin
                    shift = 1'b1;
                    if (stage_en[N_STAGES-2:0] == '0) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            path_cnt <= '0;
            num_lat  <= '0;
            aborted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            aborted <= clear;
            if (cnt_clr) begin
                path_cnt <= '0;
            end else if (cnt_inc) begin
                path_cnt <= path_cnt + CNT_W'(1);
            end
            if (lat_en) begin
                num_lat <= num_paths;
            end
        end
    end

endmodule
